// File: rtl/ram_slot_scheduler.sv
// Shared SRAM bus time-division scheduler: 8 slots per 1 us frame,
// owner chosen one slot ahead, plus the CPU clock enable.
module ram_slot_scheduler #(
  parameter int CLK_MHZ     = 64,
  parameter int SLOT_CYCLES = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       video_en_i,
  input  logic       cpu_valid_i,
  input  logic       spi_req_i,
  output logic [2:0] grant_o,
  output logic [2:0] slot_o,
  output logic       video_done_o,
  output logic       cpu_done_o,
  output logic       spi_done_o,
  output logic       cpu_clk_en_o
);

  localparam int CW = $clog2(CLK_MHZ);
  localparam int PW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_MHZ - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PH_DONE = PW'(SLOT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    VIDEO = 3'b001,
    CPU   = 3'b010,
    SPI   = 3'b100
  } own_e;

  generate
    if (CLK_MHZ != 8 * SLOT_CYCLES || SLOT_CYCLES < 4) begin : g_bad_cfg
      $fatal(1, "ram_slot_scheduler: need CLK_MHZ == 8*SLOT_CYCLES, SLOT_CYCLES >= 4");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [PW-1:0] phase;
  logic [2:0]    slot;
  logic [2:0]    slot_nxt;
  logic          last_ph;
  logic          vid_slot;
  logic          cpu_slot;
  own_e          state;
  own_e          state_nxt;

  assign last_ph  = (phase == PH_LAST);
  assign slot_nxt = (slot == 3'd7) ? 3'd0 : slot + 3'd1;
  assign vid_slot = (slot_nxt == 3'd0) || (slot_nxt == 3'd1);
  assign cpu_slot = (slot_nxt == 3'd6);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt   <= '0;
      phase <= '0;
      slot  <= '0;
      state <= IDLE;
    end else begin
      cnt   <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      phase <= last_ph ? '0 : phase + 1'b1;
      if (last_ph) slot <= slot_nxt;
      state <= state_nxt;
    end
  end

  // Owner for the next slot is decided on the last phase of this one.
  always_comb begin
    state_nxt = state;
    if (last_ph) begin
      unique case (1'b1)
        vid_slot: state_nxt = video_en_i  ? VIDEO
                            : spi_req_i   ? SPI : IDLE;
        cpu_slot: state_nxt = cpu_valid_i ? CPU
                            : spi_req_i   ? SPI : IDLE;
        default:  state_nxt = spi_req_i   ? SPI : IDLE;
      endcase
    end
  end

  always_comb begin
    grant_o      = state;
    slot_o       = slot;
    video_done_o = (state == VIDEO) && (phase == PH_DONE);
    cpu_done_o   = (state == CPU)   && (phase == PH_DONE);
    spi_done_o   = (state == SPI)   && (phase == PH_DONE);
    cpu_clk_en_o = (cnt == CNT_MAX);
  end

endmodule

// File: doc/ram_slot_scheduler.md
Name: ram_slot_scheduler

Overview:
- Time-division scheduler for the shared SRAM bus. It divides each 1 µs CPU cycle into 8 fixed slots and assigns each slot to one of three owners: video fetch, 6502 CPU, or SPI (MCU) access.
- Owns the master cycle counter and generates the CPU clock enable.
- Sits ahead of the bus arbiter datapath; grant_o selects which requester drives address/data/control for the current slot.

Parameters:
- CLK_MHZ, 64, system clock in MHz; one µs frame = CLK_MHZ cycles.
- SLOT_CYCLES, 8, clocks per slot; CLK_MHZ must equal 8*SLOT_CYCLES and SLOT_CYCLES >= 4 (elaboration-time check with $fatal).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- video_en_i  in  1  video fetch enabled (level).
- cpu_valid_i  in  1  CPU has a bus cycle this µs (level).
- spi_req_i  in  1  SPI transaction pending (level, held until done).
- grant_o  out  3  one-hot owner of current slot: [0] video, [1] cpu, [2] spi; 000 = idle.
- slot_o  out  3  current slot index 0..7.
- video_done_o  out  1  one-cycle pulse, video slot complete.
- cpu_done_o  out  1  one-cycle pulse, CPU slot complete.
- spi_done_o  out  1  one-cycle pulse, SPI slot complete.
- cpu_clk_en_o  out  1  one-cycle pulse, last clock of each µs frame.

Behaviour:
- Reset (async assert, sync release): cnt=0, grant_o=000, slot_o=0, all pulses 0. Outputs drop immediately on assert, including mid-slot. No done pulse is issued for an interrupted slot.
- Counter: cnt runs 0..CLK_MHZ-1 and wraps to 0. slot = cnt / SLOT_CYCLES. phase = cnt % SLOT_CYCLES.
- Decision timing:
  - Inputs are sampled at phase SLOT_CYCLES-1 of slot k.
  - grant_o for slot k+1 is registered on that edge and is stable for all phases of slot k+1.
  - Slot 0 after reset release is always idle, because no decision has been made yet.
- Slot map (priority within a slot):
  - Slots 0,1: video if video_en_i, else SPI if spi_req_i, else idle.
  - Slot 6: cpu if cpu_valid_i, else SPI if spi_req_i, else idle.
  - Slots 2,3,4,5,7: SPI if spi_req_i, else idle.
- State per slot: IDLE, VIDEO, CPU, SPI, encoded directly by grant_o. No other state is held.
- Done pulses:
  - The owner's done pulse is asserted at phase SLOT_CYCLES-2 of its granted slot.
  - Exactly one pulse per granted slot; none for idle slots.
- SPI handshake:
  - The requester must deassert spi_req_i on the edge after spi_done_o if it has no further work.
  - Because sampling occurs at phase SLOT_CYCLES-1, the deassert is seen, so there is no double grant.
  - A request still high at phase SLOT_CYCLES-1 is granted back-to-back.
- Simultaneous events: a request changing exactly at phase SLOT_CYCLES-1 uses the value registered at that edge. Video and cpu never compete, since their slots are disjoint.
- cpu_clk_en_o: high when cnt == CLK_MHZ-1, i.e. once per frame, in the same cycle as the slot-7 decision.
- slot_o: registered with grant_o and equals the slot of the current grant.
- Width rules: cnt is $clog2(CLK_MHZ) bits, and wrap uses an explicit compare (no reliance on overflow).

Test Plan:
- Release reset, all requests low, run 3 frames -> grant_o=000 throughout; cpu_clk_en_o pulses at cycles 63, 127, 191; no done pulses.
- video_en_i=1, cpu_valid_i=1, spi_req_i=0 -> frame 2:
  - grant=001 at cycles 64–79, video_done at 70 and 78;
  - grant=010 at cycles 112–119, cpu_done at 118;
  - remaining slots idle.
- spi_req_i held high, video_en_i=0, cpu_valid_i=0 -> from cycle 8, grant=100 every slot; spi_done at 14, 22, 30, …
- video_en_i=1, cpu_valid_i=1, spi_req_i rises at cycle 84 (slot 2), requester drops it one cycle after spi_done_o -> grant=100 at cycles 88–95, spi_done at 94, req low at 95, slot 4 (96–103) idle.
- Assert reset_i at cycle 116 during a CPU slot -> grant_o=000 immediately; no cpu_done_o; after release cnt restarts at 0 and slot 0 is idle.
